// File: rtl/ldm_stm_pkg.sv
// Shared types and constants for the LDM/STM block-transfer sequencer.
package ldm_stm_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned REG_IDX_W  = 4;
  localparam int unsigned CNT_W      = 5;
  localparam logic [REG_IDX_W-1:0] PC_IDX = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    WB   = 2'd2,
    DONE = 2'd3
  } state_e;

  // Encoding is {P,U}, so the mode falls straight out of the instruction bits.
  typedef enum logic [1:0] {
    DA = 2'b00,
    IA = 2'b01,
    DB = 2'b10,
    IB = 2'b11
  } addr_mode_e;

  function automatic addr_mode_e addr_mode(input logic p, input logic u);
    return addr_mode_e'({p, u});
  endfunction

endpackage

// File: rtl/lowest_set_bit.sv
// Combinational priority encoder: index of the lowest set bit plus a valid flag.
module lowest_set_bit
  import ldm_stm_pkg::*;
#(
  parameter int unsigned NREG = 16
) (
  input  logic [NREG-1:0]      vec,
  output logic [REG_IDX_W-1:0] idx,
  output logic                 valid
);

  // Scan from the top so the lowest set bit is the last one to win.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = int'(NREG) - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = REG_IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM sequencer: moves one register per cycle between register file and memory.
// Optional macro LDM_STM_MEM_WAIT_EN adds mem_ready so XFER cycles can stall on memory.
module ldm_stm_sequencer
  import ldm_stm_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 is_load,
  input  logic                 pre_index,
  input  logic                 up,
  input  logic                 write_back,
  input  logic [REG_IDX_W-1:0] base_reg,
  input  logic [XLEN-1:0]      base_addr,
  input  logic [NREG-1:0]      reg_list,
  input  logic [XLEN-1:0]      mem_rdata,
  input  logic [XLEN-1:0]      reg_rdata,
`ifdef LDM_STM_MEM_WAIT_EN
  input  logic                 mem_ready,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [XLEN-1:0]      mem_addr,
  output logic                 mem_we,
  output logic [XLEN-1:0]      mem_wdata,
  output logic [REG_IDX_W-1:0] reg_raddr,
  output logic                 reg_we,
  output logic [REG_IDX_W-1:0] reg_waddr,
  output logic [XLEN-1:0]      reg_wdata,
  output logic                 pc_load
);

  localparam logic [XLEN-1:0] STEP = XLEN'(WORD_BYTES);

  state_e               state_q, state_d;
  logic [NREG-1:0]      list_q;
  logic [XLEN-1:0]      addr_q;
  logic [XLEN-1:0]      wb_val_q;
  logic [REG_IDX_W-1:0] base_reg_q;
  logic                 is_load_q;
  logic                 wb_en_q;

  logic [CNT_W-1:0]     n_c;
  logic [XLEN-1:0]      span_c;
  logic [XLEN-1:0]      start_addr_c;
  logic [XLEN-1:0]      wb_val_c;
  logic                 wb_en_c;
  logic [REG_IDX_W-1:0] cur;
  logic                 cur_valid;
  logic [NREG-1:0]      list_next;
  logic                 mem_ok;
  logic                 fire;
  logic                 last;
  logic                 accept;

  lowest_set_bit #(.NREG(NREG)) u_lsb (
    .vec   (list_q),
    .idx   (cur),
    .valid (cur_valid)
  );

`ifdef LDM_STM_MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  assign mem_ok = 1'b1;
`endif

  assign accept    = (state_q == IDLE) && start;
  assign fire      = (state_q == XFER) && cur_valid && mem_ok;
  assign list_next = list_q & ~(NREG'(1) << cur);
  assign last      = (list_next == '0);

  // Launch-time arithmetic: transfer count, first address and writeback value.
  always_comb begin
    n_c = '0;
    for (int i = 0; i < int'(NREG); i++) begin
      n_c = n_c + CNT_W'(reg_list[i]);
    end
    span_c = XLEN'(n_c) * STEP;
    case (addr_mode(pre_index, up))
      IA:      start_addr_c = base_addr;
      IB:      start_addr_c = base_addr + STEP;
      DA:      start_addr_c = base_addr - span_c + STEP;
      DB:      start_addr_c = base_addr - span_c;
      default: start_addr_c = base_addr;
    endcase
    wb_val_c = up ? (base_addr + span_c) : (base_addr - span_c);
    // A loaded base or a PC base keeps the transferred value, so no writeback.
    wb_en_c  = write_back && (n_c != '0) && (base_reg != PC_IDX)
               && !(is_load && reg_list[base_reg]);
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Command latch at launch; list/address advance on each completed transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      list_q     <= '0;
      addr_q     <= '0;
      wb_val_q   <= '0;
      base_reg_q <= '0;
      is_load_q  <= 1'b0;
      wb_en_q    <= 1'b0;
    end else if (accept) begin
      list_q     <= reg_list;
      addr_q     <= start_addr_c;
      wb_val_q   <= wb_val_c;
      base_reg_q <= base_reg;
      is_load_q  <= is_load;
      wb_en_q    <= wb_en_c;
    end else if (fire) begin
      list_q     <= list_next;
      addr_q     <= addr_q + STEP;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (n_c == '0) ? DONE : XFER;
      XFER:    if (fire && last) state_d = wb_en_q ? WB : DONE;
      WB:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory read data and register read data flow through in the same cycle.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    reg_raddr = '0;
    reg_we    = 1'b0;
    reg_waddr = '0;
    reg_wdata = '0;
    pc_load   = 1'b0;
    case (state_q)
      XFER: begin
        busy     = 1'b1;
        mem_addr = addr_q;
        if (is_load_q) begin
          reg_wdata = mem_rdata;
          if (cur == PC_IDX) begin
            pc_load = fire;
          end else begin
            reg_we    = fire;
            reg_waddr = cur;
          end
        end else begin
          reg_raddr = cur;
          mem_we    = 1'b1;
          mem_wdata = reg_rdata;
        end
      end
      WB: begin
        busy      = 1'b1;
        reg_we    = 1'b1;
        reg_waddr = base_reg_q;
        reg_wdata = wb_val_q;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule
